// File: rtl/tt_scanner.sv
// Latches an N-input truth table, then sweeps every input combination once per clock,
// streaming idx/s and counting minterms/maxterms. Optional hold port: TT_SCANNER_HOLD_EN.
module tt_scanner #(
  parameter  int N    = 4,
  localparam int TT_W = 2**N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef TT_SCANNER_HOLD_EN
  input  logic            hold,
`endif
  input  logic [TT_W-1:0] table_in,
  input  logic [N-1:0]    eval_in,
  output logic            eval_s,
  output logic            busy,
  output logic            valid,
  output logic [N-1:0]    idx,
  output logic            s,
  output logic [N:0]      ones,
  output logic [N:0]      zeros,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [N-1:0] IDX_LAST = N'(TT_W - 1);

  state_t          r_state;
  logic [TT_W-1:0] r_table;
  logic [N-1:0]    r_idx;
  logic [N:0]      r_ones;
  logic [N:0]      r_zeros;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic            w_s;
  logic            w_hold;

`ifdef TT_SCANNER_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  // Gated by valid so s reads 0 outside the sweep.
  assign w_s = r_valid & r_table[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_table <= '0;
      r_idx   <= '0;
      r_ones  <= '0;
      r_zeros <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_table <= table_in;
            r_idx   <= '0;
            r_ones  <= '0;
            r_zeros <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (!w_hold) begin
            if (w_s) r_ones  <= r_ones + 1'b1;
            else     r_zeros <= r_zeros + 1'b1;
            // The last index is counted, but idx parks there instead of wrapping.
            if (r_idx == IDX_LAST) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign eval_s = r_table[eval_in];
  assign busy   = r_busy;
  assign valid  = r_valid;
  assign idx    = r_idx;
  assign s      = w_s;
  assign ones   = r_ones;
  assign zeros  = r_zeros;
  assign done   = r_done;

endmodule

// File: tb/tb_tt_scanner.sv
// Directed plus randomized bench for tt_scanner (N=4) against a bit-indexing reference
// of the truth table; hold cases apply only when TT_SCANNER_HOLD_EN is defined.
module tb_tt_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hold;
  logic [15:0] table_in;
  logic [3:0]  eval_in;
  logic        eval_s;
  logic        busy;
  logic        valid;
  logic [3:0]  idx;
  logic        s;
  logic [4:0]  ones;
  logic [4:0]  zeros;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  tt_scanner #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef TT_SCANNER_HOLD_EN
    .hold     (hold),
`endif
    .table_in (table_in),
    .eval_in  (eval_in),
    .eval_s   (eval_s),
    .busy     (busy),
    .valid    (valid),
    .idx      (idx),
    .s        (s),
    .ones     (ones),
    .zeros    (zeros),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_idx"},   idx,   0);
    chk({tag, "_s"},     s,     0);
    chk({tag, "_ones"},  ones,  0);
    chk({tag, "_zeros"}, zeros, 0);
    chk({tag, "_evals"}, eval_s, 0);
  endtask

  // Reference: sample i of a scan is tbl[i]; counts before sample i are the ones/zeros
  // among tbl[0..i-1]; DONE shows the full popcount. start_at/rst_at/hold_at = -1 disables.
  task automatic scan(input logic [15:0] tbl, input int start_at, input logic [15:0] alt,
                      input int rst_at, input int hold_at);
    int ones_m  = 0;
    int zeros_m = 0;
    int vcount  = 0;
    int vexp    = 16;
    bit aborted = 0;
    @(negedge clk);
    table_in = tbl;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      table_in = 16'($urandom);
      chk("scan_valid", valid, 1);
      chk("scan_busy",  busy,  1);
      chk("scan_done",  done,  0);
      chk("scan_idx",   idx,   i);
      chk("scan_s",     s,     tbl[i]);
      chk("scan_ones",  ones,  ones_m);
      chk("scan_zeros", zeros, zeros_m);
      vcount++;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk_cleared("midrst");
        #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (i == start_at) begin
        start    = 1'b1;
        table_in = alt;
      end else begin
        start = 1'b0;
      end
`ifdef TT_SCANNER_HOLD_EN
      if (i == hold_at) begin
        hold = 1'b1;
        vexp = 19;
        repeat (3) begin
          @(negedge clk);
          chk("hold_valid", valid, 1);
          chk("hold_idx",   idx,   i);
          chk("hold_s",     s,     tbl[i]);
          chk("hold_ones",  ones,  ones_m);
          vcount++;
        end
        hold = 1'b0;
      end
`endif
      if (tbl[i]) ones_m++;
      else        zeros_m++;
    end
    @(negedge clk);
    start = 1'b0;
    if (!aborted) begin
      chk("done_pulse", done,   1);
      chk("done_valid", valid,  0);
      chk("done_busy",  busy,   1);
      chk("done_ones",  ones,   $countones(tbl));
      chk("done_zeros", zeros,  16 - $countones(tbl));
      chk("valid_cyc",  vcount, vexp);
      @(negedge clk);
      chk("idle_done",  done,  0);
      chk("idle_busy",  busy,  0);
      chk("idle_ones",  ones,  $countones(tbl));
      chk("idle_zeros", zeros, 16 - $countones(tbl));
    end else begin
      chk("postrst_done",  done,  0);
      chk("postrst_valid", valid, 0);
      chk("postrst_busy",  busy,  0);
      chk("postrst_ones",  ones,  0);
    end
  endtask

  initial begin
    logic [15:0] t;
    logic [3:0]  e;
    rst = 1'b1; start = 1'b0; hold = 1'b0; table_in = '0; eval_in = '0;

    // Reset sequence
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("inrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cleared("reset");
    for (int v = 0; v < 16; v++) begin
      eval_in = 4'(v);
      #1;
      chk("reset_eval", eval_s, 0);
    end

    // PoS(0,1,6,7,8,9,C,E) and direct lookup
    scan(16'hAC3C, -1, 16'h0, -1, -1);
    eval_in = 4'b0010; #1; chk("lookup_0010", eval_s, 1);
    eval_in = 4'b1100; #1; chk("lookup_1100", eval_s, 0);

    // Boundary tables
    scan(16'h0000, -1, 16'h0, -1, -1);
    scan(16'hFFFF, -1, 16'h0, -1, -1);

    // Start and table change mid-scan are ignored
    scan(16'hAC3C, 5, 16'h0001, -1, -1);
    eval_in = 4'd0; #1; chk("ignored_latch", eval_s, 0);
    scan(16'h0001, -1, 16'h0, -1, -1);
    eval_in = 4'd0; #1; chk("later_latch", eval_s, 1);

    // Reset mid-scan, then a fresh scan (with hold when enabled)
    scan(16'hAC3C, -1, 16'h0, 9, -1);
    scan(16'hAC3C, -1, 16'h0, -1, 4);

    // Randomized tables with random lookups
    repeat (6) begin
      t = 16'($urandom);
      scan(t, int'($urandom_range(0, 20)) - 5, 16'($urandom), -1, int'($urandom_range(0, 15)));
      repeat (4) begin
        e = 4'($urandom);
        eval_in = e;
        #1;
        chk("rand_lookup", eval_s, t[e]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
